// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver (common anode, active-low outputs).
// New values are buffered in a shadow register and switched in only at frame boundaries.
module seg7_scan_driver #(
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] disp_num,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [7:0]  segment,
    output logic [3:0]  anode,
    output logic        frame_done,
    output logic        pending
);

    localparam int                CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

    typedef struct packed {
        logic [15:0] num;
        logic [3:0]  dp;
    } frame_t;

    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [1:0]            digit_q,     digit_d;
    frame_t                shadow_q,    shadow_d;
    frame_t                show_q,      show_d;
    logic [BLINK_LOG2-1:0] frame_cnt_q, frame_cnt_d;
    logic                  pending_q,   pending_d;
    logic [7:0]            segment_q,   segment_d;
    logic [3:0]            anode_q,     anode_d;
    logic                  frame_done_q, frame_done_d;

    logic       tick;
    logic       boundary;
    frame_t     incoming;
    logic [3:0] nibble;
    logic [3:0] zero_from;
    logic       blanked;
    logic       blink_off;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        tick     = (cnt_q == CNT_MAX);
        boundary = tick && (digit_q == 2'd3);
        incoming = '{num: disp_num, dp: dp_mask};

        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        digit_d      = tick ? digit_q + 2'd1 : digit_q;
        shadow_d     = load ? incoming : shadow_q;
        show_d       = show_q;
        pending_d    = pending_q;
        frame_cnt_d  = boundary ? frame_cnt_q + 1'b1 : frame_cnt_q;
        frame_done_d = boundary;

        // A load coinciding with the boundary bypasses the shadow so it is not held a whole frame.
        if (boundary) begin
            if (load) begin
                show_d = incoming;
            end else if (pending_q) begin
                show_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end

        // Rendering looks at the post-edge digit and display value so a new frame starts clean.
        nibble       = show_d.num[{digit_d, 2'b00} +: 4];
        zero_from[3] = (show_d.num[15:12] == 4'h0);
        zero_from[2] = zero_from[3] && (show_d.num[11:8] == 4'h0);
        zero_from[1] = zero_from[2] && (show_d.num[7:4] == 4'h0);
        zero_from[0] = 1'b0;
        blanked      = blank_lz && zero_from[digit_d];
        blink_off    = blink_en && frame_cnt_d[BLINK_LOG2-1];

        segment_d = segment_q;
        anode_d   = anode_q;
        if (tick) begin
            segment_d = blanked ? 8'hFF : {~show_d.dp[digit_d], hex_to_seg(nibble)};
            anode_d   = (blanked || blink_off) ? 4'hF : ~(4'b0001 << digit_d);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            digit_q      <= 2'd3;
            shadow_q     <= '0;
            show_q       <= '0;
            frame_cnt_q  <= '0;
            pending_q    <= 1'b0;
            segment_q    <= 8'hFF;
            anode_q      <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            show_q       <= show_d;
            frame_cnt_q  <= frame_cnt_d;
            pending_q    <= pending_d;
            segment_q    <= segment_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign segment    = segment_q;
    assign anode      = anode_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, BLINK_LOG2=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] disp_num;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic        blink_en;
    logic [7:0]  segment;
    logic [3:0]  anode;
    logic        frame_done;
    logic        pending;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .SCAN_DIV  (4),
        .BLINK_LOG2(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .disp_num  (disp_num),
        .dp_mask   (dp_mask),
        .blank_lz  (blank_lz),
        .blink_en  (blink_en),
        .segment   (segment),
        .anode     (anode),
        .frame_done(frame_done),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
        check({tag, ".anode"}, {4'h0, anode}, {4'h0, exp_an});
        check({tag, ".segment"}, segment, exp_seg);
    endtask

    task automatic chk_flags(input string tag, input logic exp_fd, input logic exp_pend);
        check({tag, ".frame_done"}, {7'd0, frame_done}, {7'd0, exp_fd});
        check({tag, ".pending"}, {7'd0, pending}, {7'd0, exp_pend});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; disp_num = '0; dp_mask = '0;
        blank_lz = 1'b0; blink_en = 1'b0;
        step(2);
        chk_out("reset", 4'hF, 8'hFF);
        chk_flags("reset", 1'b0, 1'b0);

        // Release reset with a load on the first edge; edge 4 is the first boundary.
        rst = 1'b1; load = 1'b1; disp_num = 16'h1A2F;
        step(1); load = 1'b0;
        chk_flags("load1", 1'b0, 1'b1);
        chk_out("pre_tick", 4'hF, 8'hFF);
        step(3); chk_flags("bnd1", 1'b1, 1'b0); chk_out("f1d0", 4'hE, 8'h8E);
        step(1); chk_flags("bnd1_end", 1'b0, 1'b0);
        step(3); chk_out("f1d1", 4'hD, 8'hA4);
        step(4); chk_out("f1d2", 4'hB, 8'h88);
        step(4); chk_out("f1d3", 4'h7, 8'hF9);
        step(4); chk_out("f2d0", 4'hE, 8'h8E); chk_flags("bnd2", 1'b1, 1'b0);

        // Mid-frame load while digit 1 is shown.
        step(4); chk_out("f2d1", 4'hD, 8'hA4);
        load = 1'b1; disp_num = 16'h0003;
        step(1); load = 1'b0; chk_flags("mid_load", 1'b0, 1'b1);
        step(3); chk_out("mid_d2", 4'hB, 8'h88); chk_flags("mid_d2", 1'b0, 1'b1);
        step(4); chk_out("mid_d3", 4'h7, 8'hF9); chk_flags("mid_d3", 1'b0, 1'b1);
        step(4); chk_out("new_d0", 4'hE, 8'hB0); chk_flags("new_bnd", 1'b1, 1'b0);
        step(4); chk_out("new_d1", 4'hD, 8'hC0);

        // Two loads in one frame: last one wins.
        load = 1'b1; disp_num = 16'h1111;
        step(1); disp_num = 16'h2222;
        step(1); load = 1'b0;
        step(2); chk_out("dbl_d2", 4'hB, 8'hC0); chk_flags("dbl_d2", 1'b0, 1'b1);
        step(4); chk_out("dbl_d3", 4'h7, 8'hC0);
        step(4); chk_out("dbl_d0", 4'hE, 8'hA4); chk_flags("dbl_bnd", 1'b1, 1'b0);
        step(4); chk_out("dbl_d1", 4'hD, 8'hA4);

        // Load on the exact boundary edge goes straight to the display.
        step(11); load = 1'b1; disp_num = 16'h00C0;
        step(1); load = 1'b0;
        chk_flags("bload_bnd", 1'b1, 1'b0); chk_out("bload_d0", 4'hE, 8'hC0);
        step(1); chk_flags("bload_after", 1'b0, 1'b0);
        step(3); chk_out("bload_d1", 4'hD, 8'hC6);

        // Leading-zero blanking.
        blank_lz = 1'b1; load = 1'b1; disp_num = 16'h0005;
        step(1); load = 1'b0;
        step(3); chk_out("lz_old_d2", 4'hF, 8'hFF);
        step(4); chk_out("lz_old_d3", 4'hF, 8'hFF);
        step(4); chk_out("lz5_d0", 4'hE, 8'h92); chk_flags("lz5_bnd", 1'b1, 1'b0);
        step(4); chk_out("lz5_d1", 4'hF, 8'hFF);
        step(4); chk_out("lz5_d2", 4'hF, 8'hFF);
        step(4); chk_out("lz5_d3", 4'hF, 8'hFF);
        load = 1'b1; disp_num = 16'h0000;
        step(1); load = 1'b0;
        step(3); chk_out("lz0_d0", 4'hE, 8'hC0);
        step(4); chk_out("lz0_d1", 4'hF, 8'hFF);

        // Blinking with a decimal point on digit 0; the frame starting at edge 100 is odd.
        blank_lz = 1'b0; blink_en = 1'b1; load = 1'b1; disp_num = 16'h1234; dp_mask = 4'b0001;
        step(1); load = 1'b0;
        step(3); chk_out("blk_odd_d2", 4'hF, 8'hC0);
        step(4); chk_out("blk_odd_d3", 4'hF, 8'hC0);
        step(4); chk_out("blk_even_d0", 4'hE, 8'h19);
        step(4); chk_out("blk_even_d1", 4'hD, 8'hB0);
        step(4); chk_out("blk_even_d2", 4'hB, 8'hA4);
        step(4); chk_out("blk_even_d3", 4'h7, 8'hF9);
        step(4); chk_out("blk_odd2_d0", 4'hF, 8'h19);
        step(4); chk_out("blk_odd2_d1", 4'hF, 8'hB0);
        step(4); chk_out("blk_odd2_d2", 4'hF, 8'hA4);
        step(4); chk_out("blk_odd2_d3", 4'hF, 8'hF9);
        step(4); chk_out("blk_even2_d0", 4'hE, 8'h19);

        // Reset mid-frame with a pending value: the value must be discarded.
        load = 1'b1; disp_num = 16'h5555; dp_mask = 4'hF;
        step(1); load = 1'b0; chk_flags("rst_pend", 1'b0, 1'b1);
        step(1); rst = 1'b0;
        #1;
        chk_out("rst_mid", 4'hF, 8'hFF); chk_flags("rst_mid", 1'b0, 1'b0);
        step(1); rst = 1'b1; blink_en = 1'b0; dp_mask = 4'h0;
        step(3); chk_out("rst_pre", 4'hF, 8'hFF); chk_flags("rst_pre", 1'b0, 1'b0);
        step(1); chk_out("rst_d0", 4'hE, 8'hC0); chk_flags("rst_bnd", 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
